// File: rtl/v_issue_pkg.sv
// rtl/v_issue_pkg.sv - shared types and opcode helpers for the vector instruction issue queue
package v_issue_pkg;

    localparam logic [6:0] OPC_VLOAD  = 7'b0000111;
    localparam logic [6:0] OPC_VSTORE = 7'b0100111;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } v_issue_entry_t;

    function automatic logic is_load(input logic [31:0] instr);
        return instr[6:0] == OPC_VLOAD;
    endfunction

    function automatic logic is_store(input logic [31:0] instr);
        return instr[6:0] == OPC_VSTORE;
    endfunction

endpackage

// File: rtl/v_issue_fifo.sv
// rtl/v_issue_fifo.sv - circular buffer of issue entries with occupancy count
module v_issue_fifo
    import v_issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           push_i,
    input  logic           pop_i,
    input  v_issue_entry_t wdata_i,
    output v_issue_entry_t rdata_o,
    output logic           full_o,
    output logic           empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W:0]   count_q, count_d;
    v_issue_entry_t   mem_q [DEPTH];

    // Storage is not reset: an empty queue masks the head to zero, so stale data never leaks.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (push_i) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/v_instr_issue_queue.sv
// rtl/v_instr_issue_queue.sv - vector instruction decoupling queue with load/store outstanding tracking
module v_instr_issue_queue
    import v_issue_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        instr_valid_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic        stall_o,
    output logic [31:0] vector_instr_o,
    output logic [31:0] rs1_o,
    output logic [31:0] rs2_o,
    input  logic        vector_stall_i,
    input  logic        v_load_done_i,
    input  logic        v_store_done_i,
    output logic        all_v_loads_executed_o,
    output logic        all_v_stores_executed_o,
    output logic        err_o
);

    localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic           push, pop, full, empty;
    logic           push_ld, push_st;
    v_issue_entry_t wr_entry, head;

    logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d;
    logic [CNT_W-1:0] st_cnt_q, st_cnt_d;
    logic             err_q, err_d;

    // A full queue stalls even when the head pops this cycle; there is no full-bypass.
    assign stall_o = full
                   || ((ld_cnt_q == MAX_CNT) && is_load(instr_i))
                   || ((st_cnt_q == MAX_CNT) && is_store(instr_i));

    assign push    = instr_valid_i && !stall_o;
    assign pop     = !empty && !vector_stall_i;
    assign push_ld = push && is_load(instr_i);
    assign push_st = push && is_store(instr_i);

    assign wr_entry = '{instr: instr_i, rs1: rs1_i, rs2: rs2_i};

    v_issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        ld_cnt_d = ld_cnt_q;
        st_cnt_d = st_cnt_q;
        err_d    = err_q
                 | (v_load_done_i  && (ld_cnt_q == '0))
                 | (v_store_done_i && (st_cnt_q == '0));
        if (push_ld && !v_load_done_i) begin
            ld_cnt_d = ld_cnt_q + CNT_W'(1);
        end else if (!push_ld && v_load_done_i && (ld_cnt_q != '0)) begin
            ld_cnt_d = ld_cnt_q - CNT_W'(1);
        end
        if (push_st && !v_store_done_i) begin
            st_cnt_d = st_cnt_q + CNT_W'(1);
        end else if (!push_st && v_store_done_i && (st_cnt_q != '0)) begin
            st_cnt_d = st_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ld_cnt_q <= '0;
            st_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            ld_cnt_q <= ld_cnt_d;
            st_cnt_q <= st_cnt_d;
            err_q    <= err_d;
        end
    end

    assign vector_instr_o          = head.instr;
    assign rs1_o                   = head.rs1;
    assign rs2_o                   = head.rs2;
    assign all_v_loads_executed_o  = (ld_cnt_q == '0);
    assign all_v_stores_executed_o = (st_cnt_q == '0);
    assign err_o                   = err_q;

endmodule

// File: tb/tb_v_instr_issue_queue.sv
// tb/tb_v_instr_issue_queue.sv - scenario and randomized checks of the issue queue against a queue-based model
module tb_v_instr_issue_queue;

    localparam int         DEPTH   = 4;
    localparam int         MAX_OUT = 15;
    localparam logic [6:0] LD      = 7'b0000111;
    localparam logic [6:0] ST      = 7'b0100111;
    localparam logic [6:0] ARITH   = 7'b1010111;

    logic        clk = 1'b0;
    logic        rstn;
    logic        instr_valid_i, vector_stall_i, v_load_done_i, v_store_done_i;
    logic [31:0] instr_i, rs1_i, rs2_i;
    logic        stall_o, all_v_loads_executed_o, all_v_stores_executed_o, err_o;
    logic [31:0] vector_instr_o, rs1_o, rs2_o;

    int checks   = 0;
    int failures = 0;

    logic [95:0] mq[$];
    int          m_ld, m_st;
    bit          m_err;

    always #5 clk = ~clk;

    v_instr_issue_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk                     (clk),
        .rstn                    (rstn),
        .instr_valid_i           (instr_valid_i),
        .instr_i                 (instr_i),
        .rs1_i                   (rs1_i),
        .rs2_i                   (rs2_i),
        .stall_o                 (stall_o),
        .vector_instr_o          (vector_instr_o),
        .rs1_o                   (rs1_o),
        .rs2_o                   (rs2_o),
        .vector_stall_i          (vector_stall_i),
        .v_load_done_i           (v_load_done_i),
        .v_store_done_i          (v_store_done_i),
        .all_v_loads_executed_o  (all_v_loads_executed_o),
        .all_v_stores_executed_o (all_v_stores_executed_o),
        .err_o                   (err_o)
    );

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [24:0] tag);
        return {tag, opc};
    endfunction

    function automatic bit m_stall();
        return (mq.size() == DEPTH)
            || (m_ld == MAX_OUT && instr_i[6:0] == LD)
            || (m_st == MAX_OUT && instr_i[6:0] == ST);
    endfunction

    function automatic logic [95:0] m_head();
        return (mq.size() != 0) ? mq[0] : 96'h0;
    endfunction

    task automatic idle_inputs();
        instr_valid_i  = 1'b0;
        instr_i        = 32'h0;
        rs1_i          = 32'h0;
        rs2_i          = 32'h0;
        vector_stall_i = 1'b0;
        v_load_done_i  = 1'b0;
        v_store_done_i = 1'b0;
    endtask

    // Advance one clock; the model applies the queue and counter rules at the edge.
    task automatic tick();
        bit push, pop;
        int pl, ps;
        push = instr_valid_i && !m_stall();
        pop  = (mq.size() != 0) && !vector_stall_i;
        pl   = (push && instr_i[6:0] == LD) ? 1 : 0;
        ps   = (push && instr_i[6:0] == ST) ? 1 : 0;
        @(posedge clk);
        #1;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back({instr_i, rs1_i, rs2_i});
        if (v_load_done_i && m_ld == 0) m_err = 1;
        if (v_store_done_i && m_st == 0) m_err = 1;
        m_ld = m_ld + pl - int'(v_load_done_i);
        m_st = m_st + ps - int'(v_store_done_i);
        if (m_ld < 0) m_ld = 0;
        if (m_st < 0) m_st = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        #12;
        mq.delete();
        m_ld = 0; m_st = 0; m_err = 0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
        checks++; if (vector_instr_o !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", vector_instr_o); end
        checks++; if ({rs1_o, rs2_o} !== 64'h0) begin failures++; $display("FAIL reset_rs got=%h exp=0", {rs1_o, rs2_o}); end
        checks++; if (all_v_loads_executed_o !== 1'b1) begin failures++; $display("FAIL reset_all_ld got=%b exp=1", all_v_loads_executed_o); end
        checks++; if (all_v_stores_executed_o !== 1'b1) begin failures++; $display("FAIL reset_all_st got=%b exp=1", all_v_stores_executed_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_o); end
    endtask

    task automatic test_pass_through();
        instr_valid_i = 1'b1; instr_i = 32'h0200_7087; rs1_i = 32'h1000; rs2_i = 32'h0;
        #2;
        checks++; if (vector_instr_o !== 32'h0) begin failures++; $display("FAIL pt_no_bypass got=%h exp=0", vector_instr_o); end
        tick();
        idle_inputs();
        #2;
        checks++; if (vector_instr_o !== 32'h0200_7087) begin failures++; $display("FAIL pt_instr got=%h exp=02007087", vector_instr_o); end
        checks++; if (rs1_o !== 32'h1000) begin failures++; $display("FAIL pt_rs1 got=%h exp=1000", rs1_o); end
        checks++; if (all_v_loads_executed_o !== 1'b0) begin failures++; $display("FAIL pt_ld_busy got=%b exp=0", all_v_loads_executed_o); end
        tick();
        v_load_done_i = 1'b1;
        tick();
        idle_inputs();
        #2;
        checks++; if (all_v_loads_executed_o !== 1'b1) begin failures++; $display("FAIL pt_ld_done got=%b exp=1", all_v_loads_executed_o); end
        checks++; if (vector_instr_o !== 32'h0) begin failures++; $display("FAIL pt_empty got=%h exp=0", vector_instr_o); end
    endtask

    task automatic test_fill_drain();
        logic [31:0] exp [4];
        vector_stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp[i] = mk(ARITH, 25'(16'hA0 + i));
            instr_valid_i = 1'b1; instr_i = exp[i]; rs1_i = 32'(i); rs2_i = 32'(i + 100);
            #2;
            checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL fill_stall%0d got=%b exp=0", i, stall_o); end
            tick();
        end
        instr_i = mk(ARITH, 25'h1FF);
        #2;
        checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL fill_full_stall got=%b exp=1", stall_o); end
        tick();
        #2;
        checks++; if (vector_instr_o !== exp[0]) begin failures++; $display("FAIL fill_head_stable got=%h exp=%h", vector_instr_o, exp[0]); end
        instr_valid_i = 1'b0;
        vector_stall_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++; if ({vector_instr_o, rs1_o, rs2_o} !== {exp[i], 32'(i), 32'(i + 100)})
                begin failures++; $display("FAIL drain%0d got=%h exp=%h", i, vector_instr_o, exp[i]); end
            tick();
        end
        #2;
        checks++; if ({vector_instr_o, rs1_o, rs2_o} !== 96'h0) begin failures++; $display("FAIL drain_empty got=%h exp=0", vector_instr_o); end
    endtask

    task automatic test_simul_push_pop();
        logic [31:0] seq [12];
        for (int i = 0; i < 12; i++) seq[i] = mk(ARITH, 25'(16'hC00 + i));
        vector_stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            instr_valid_i = 1'b1; instr_i = seq[i]; rs1_i = 32'h0; rs2_i = 32'h0;
            tick();
        end
        vector_stall_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            instr_valid_i = 1'b1; instr_i = seq[k + 2];
            #2;
            checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL simul_stall%0d got=%b exp=0", k, stall_o); end
            checks++; if (vector_instr_o !== seq[k]) begin failures++; $display("FAIL simul_head%0d got=%h exp=%h", k, vector_instr_o, seq[k]); end
            tick();
        end
        instr_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            checks++; if (vector_instr_o !== ((k < 2) ? seq[10 + k] : 32'h0))
                begin failures++; $display("FAIL simul_tail%0d got=%h exp=%h", k, vector_instr_o, (k < 2) ? seq[10 + k] : 32'h0); end
            tick();
        end
    endtask

    task automatic test_outstanding();
        do_reset();
        for (int i = 0; i < MAX_OUT; i++) begin
            instr_valid_i = 1'b1; instr_i = mk(ST, 25'(i)); rs1_i = 32'h0; rs2_i = 32'h0;
            #2;
            checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL st_fill%0d got=%b exp=0", i, stall_o); end
            tick();
        end
        instr_i = mk(ST, 25'h99);
        #2;
        checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL st_limit got=%b exp=1", stall_o); end
        instr_i = mk(ARITH, 25'h77);
        #2;
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL st_arith_ok got=%b exp=0", stall_o); end
        tick();
        instr_i = mk(ST, 25'h99);
        v_store_done_i = 1'b1;
        #2;
        checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL st_done_cycle got=%b exp=1", stall_o); end
        tick();
        v_store_done_i = 1'b0;
        #2;
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL st_admit got=%b exp=0", stall_o); end
        tick();
        instr_valid_i = 1'b0;
        #2;
        checks++; if (all_v_stores_executed_o !== 1'b0) begin failures++; $display("FAIL st_busy got=%b exp=0", all_v_stores_executed_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL st_no_err got=%b exp=0", err_o); end
    endtask

    task automatic test_same_cycle_load();
        do_reset();
        instr_valid_i = 1'b1; instr_i = mk(LD, 25'h1);
        tick();
        instr_i = mk(LD, 25'h2); v_load_done_i = 1'b1;
        tick();
        instr_valid_i = 1'b0;
        tick();
        v_load_done_i = 1'b0;
        #2;
        checks++; if (all_v_loads_executed_o !== 1'b1) begin failures++; $display("FAIL same_cycle_ld got=%b exp=1", all_v_loads_executed_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL same_cycle_err got=%b exp=0", err_o); end
        v_load_done_i = 1'b1;
        tick();
        v_load_done_i = 1'b0;
        #2;
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL underflow_err got=%b exp=1", err_o); end
        checks++; if (all_v_loads_executed_o !== 1'b1) begin failures++; $display("FAIL underflow_cnt got=%b exp=1", all_v_loads_executed_o); end
        instr_valid_i = 1'b1; instr_i = mk(LD, 25'h3);
        tick();
        instr_valid_i = 1'b0;
        v_load_done_i = 1'b1;
        tick();
        v_load_done_i = 1'b0;
        #2;
        checks++; if (all_v_loads_executed_o !== 1'b1) begin failures++; $display("FAIL underflow_floor got=%b exp=1", all_v_loads_executed_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        vector_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr_valid_i = 1'b1; instr_i = mk((i == 1) ? ST : LD, 25'(16'hE0 + i)); rs1_i = 32'hDEAD; rs2_i = 32'hBEEF;
            tick();
        end
        instr_valid_i = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (vector_instr_o !== 32'h0) begin failures++; $display("FAIL rmid_instr got=%h exp=0", vector_instr_o); end
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL rmid_stall got=%b exp=0", stall_o); end
        checks++; if ({all_v_loads_executed_o, all_v_stores_executed_o} !== 2'b11)
            begin failures++; $display("FAIL rmid_all got=%b exp=11", {all_v_loads_executed_o, all_v_stores_executed_o}); end
        mq.delete();
        m_ld = 0; m_st = 0; m_err = 0;
        @(negedge clk);
        rstn = 1'b1;
        vector_stall_i = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++; if ({vector_instr_o, rs1_o, rs2_o} !== 96'h0) begin failures++; $display("FAIL rmid_ghost%0d got=%h exp=0", i, vector_instr_o); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [6:0] opc;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 2))
                0: opc = LD;
                1: opc = ST;
                default: opc = ARITH;
            endcase
            instr_valid_i  = ($urandom_range(0, 3) != 0);
            instr_i        = {25'($urandom), opc};
            rs1_i          = $urandom;
            rs2_i          = $urandom;
            vector_stall_i = ($urandom_range(0, 2) == 0);
            v_load_done_i  = ($urandom_range(0, 4) == 0);
            v_store_done_i = ($urandom_range(0, 4) == 0);
            #2;
            checks++; if (stall_o !== m_stall()) begin failures++; $display("FAIL rnd_stall@%0d got=%b exp=%b", n, stall_o, m_stall()); end
            checks++; if ({vector_instr_o, rs1_o, rs2_o} !== m_head())
                begin failures++; $display("FAIL rnd_head@%0d got=%h exp=%h", n, {vector_instr_o, rs1_o, rs2_o}, m_head()); end
            checks++; if ({all_v_loads_executed_o, all_v_stores_executed_o, err_o} !== {m_ld == 0, m_st == 0, m_err})
                begin failures++; $display("FAIL rnd_status@%0d got=%b exp=%b", n, {all_v_loads_executed_o, all_v_stores_executed_o, err_o}, {m_ld == 0, m_st == 0, m_err}); end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        rstn = 1'b1;
        m_ld = 0; m_st = 0; m_err = 0;
        test_reset();
        test_pass_through();
        test_fill_drain();
        test_simul_push_pop();
        test_outstanding();
        test_same_cycle_load();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/v_instr_issue_queue.md
# v_instr_issue_queue

Decoupling queue between the scalar core's vector-dispatch outputs and the vector core's `vector_instr_i`/`rs1_i`/`rs2_i` inputs inside `riscv_v`. It buffers vector instructions together with their scalar operands, so short vector stalls do not immediately freeze the scalar pipeline. It also tracks outstanding vector loads and stores to produce the `all_v_loads_executed`/`all_v_stores_executed` status that the scalar core uses for memory ordering.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of 2, ≥2.
- `MAX_OUTSTANDING`, 15: maximum vector loads, and separately maximum vector stores, in flight.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rstn` in 1: reset, asynchronous and active-low.
- `instr_valid_i` in 1: the scalar core presents a vector instruction this cycle.
- `instr_i` in 32: vector instruction word.
- `rs1_i` in 32: scalar operand 1 for the instruction.
- `rs2_i` in 32: scalar operand 2 for the instruction.
- `stall_o` out 1: queue cannot accept; the scalar core holds its vector instruction.
- `vector_instr_o` out 32: head instruction; all-zero when the queue is empty (no-op).
- `rs1_o` out 32: head operand 1; zero when empty.
- `rs2_o` out 32: head operand 2; zero when empty.
- `vector_stall_i` in 1: vector core busy; the head is not consumed.
- `v_load_done_i` in 1: one-cycle pulse; one vector load has completed.
- `v_store_done_i` in 1: one-cycle pulse; one vector store has completed.
- `all_v_loads_executed_o` out 1: no vector load is queued or in flight.
- `all_v_stores_executed_o` out 1: no vector store is queued or in flight.
- `err_o` out 1: sticky; a done pulse arrived while the matching counter was 0.

## Operation
- Each entry holds {`instr`, `rs1`, `rs2`} (96 bits). Storage is a circular buffer with read pointer `rptr`, write pointer `wptr` (log2(DEPTH) bits, natural wrap) and `count` (log2(DEPTH)+1 bits).
- **Push:** occurs when `instr_valid_i && !stall_o`. The entry is written at `wptr` and `wptr` increments.
- **Pop:** occurs when `count != 0 && !vector_stall_i`. `rptr` increments.
- **Stall condition:** `stall_o = (count == DEPTH) || (ld_cnt == MAX_OUTSTANDING && is_load(instr_i)) || (st_cnt == MAX_OUTSTANDING && is_store(instr_i))`. It is combinational from registered state and `instr_i`.
- **Instruction classification** uses opcode `instr_i[6:0]`:
  - `7'b0000111` is a vector load.
  - `7'b0100111` is a vector store.
  - Anything else is neither.
- **Load counter `ld_cnt`:** +1 on push of a load, −1 on `v_load_done_i`. If both happen in the same cycle, the value is unchanged.
- **Store counter `st_cnt`:** same rules as `ld_cnt`, using stores and `v_store_done_i`.
- **Underflow:** a done pulse while the counter is 0 leaves the counter at 0 and sets `err_o`. Only reset clears `err_o`.
- `all_v_loads_executed_o = (ld_cnt == 0)`; `all_v_stores_executed_o = (st_cnt == 0)`. Both are registered-state derived.
- No state machine beyond the queue: the queue is EMPTY when `count == 0`, PARTIAL when 0 < `count` < DEPTH, and FULL when `count == DEPTH`.

## Timing
- **Reset values:**
  - `stall_o` = 0 (with `instr_i` don't-care).
  - `vector_instr_o`, `rs1_o`, `rs2_o` = 0.
  - `all_v_*_executed_o` = 1.
  - `err_o` = 0.
  - Pointers, `count` and counters = 0.
- **Latency:** an instruction pushed in cycle N appears on `vector_instr_o` in cycle N+1 if the queue was empty. There is no same-cycle bypass.
- **Head outputs** are combinational reads at `rptr` and stay stable while `vector_stall_i` = 1.
- **Push and pop in the same cycle while PARTIAL:** both occur and `count` is unchanged.
- **Queue FULL:** `stall_o` = 1 even if a pop happens this cycle. No full-bypass; the push is accepted the next cycle.
- **Queue EMPTY:** a pop is impossible, and `vector_stall_i` is ignored.
- **Pointer wrap** from DEPTH−1 to 0 is transparent.
- **Reset asserted mid-operation:** all queued entries are discarded and outputs return to reset values asynchronously.

## Structure
- Package `v_issue_pkg` holds:
  - `OPC_VLOAD` and `OPC_VSTORE` localparams.
  - typedef struct packed `v_issue_entry_t` {`instr`, `rs1`, `rs2`}.
  - functions `is_load`/`is_store`.
- One sub-module, `v_issue_fifo`: storage, pointers, `count`, full/empty.
- The top level adds stall generation, the outstanding counters and the error flag.

## Test plan
- **Basic pass-through:** after reset, push `instr_i=32'h0200_7087` (a load), `rs1_i=32'h1000` with `vector_stall_i=0`. Required: cycle+1 shows that instr and `rs1_o=32'h1000`; `all_v_loads_executed_o` goes 0; a `v_load_done_i` pulse returns it to 1.
- **Fill and drain:** hold `vector_stall_i=1` and push 4 distinct instrs (DEPTH=4). Required: `stall_o`=1 after the 4th; a 5th is held off. Then release the stall. Required: outputs appear in FIFO order on consecutive cycles, then all-zero.
- **Simultaneous push and pop** at `count`=2 for 10 cycles. Required: `count` stays 2; order is preserved across pointer wrap.
- **Outstanding limit:** push 15 stores with no done pulses. Required: a 16th store causes `stall_o`=1, while a non-memory instr is still accepted. A single `v_store_done_i` then admits the 16th store.
- **Same-cycle load push and done** at `ld_cnt`=1. Required: `ld_cnt` stays 1. A done pulse at `ld_cnt`=0 sets `err_o` and leaves `ld_cnt` at 0.
- **Reset mid-operation** with 3 entries queued. Required: `vector_instr_o`=0, `stall_o`=0 and both `all_v_*_executed_o`=1 immediately, and the old entries never reappear.
